mem_bus_master: RTL and testbench
=================================

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 Parameter: TIMEOUT, default 255, max consecutive waitrequest-high cycles before an access is abandoned.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 req_valid  input  1  CPU requests an access this cycle.
REQ-005 req_write  input  1  1 = write, 0 = read.
REQ-006 req_addr  input  32  byte address; must be word-aligned.
REQ-007 req_wdata  input  32  write data, little-endian (byte at addr in bits 7:0).
REQ-008 req_byteenable  input  4  active byte lanes; bit n enables bits 8n+7:8n.
REQ-009 req_ready  output  1  block accepts a request this cycle.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_err  output  1  qualifies rsp_valid: misaligned address or timeout.
REQ-012 rsp_rdata  output  32  read data; valid while rsp_valid=1 for a read.
REQ-013 address  output  32  bus address.
REQ-014 read / write  output  1 each  bus strobes; never both high.
REQ-015 writedata  output  32  bus write data.
REQ-016 byteenable  output  4  bus byte enables.
REQ-017 waitrequest  input  1  responder stall; transfer completes in a cycle where strobe=1 and waitrequest=0.
REQ-018 readdata  input  32  responder data, valid the cycle after a completed read.

Function
REQ-019 FSM states SHALL be IDLE, BUS, RDATA; req_ready SHALL equal (state==IDLE).
REQ-020 IDLE, req_valid=1, req_addr[1:0]!=0: no bus access; next cycle rsp_valid=1, rsp_err=1; remain IDLE.
REQ-021 IDLE, req_valid=1, write with req_byteenable=0: no bus access; next cycle rsp_valid=1, rsp_err=0.
REQ-022 IDLE, req_valid=1, otherwise: latch write, addr, wdata, byteenable; clear timeout counter; go BUS.
REQ-023 BUS: drive read or write per latched type; address, writedata, byteenable held stable from latched values until the transfer completes.
REQ-024 BUS, waitrequest=0, write: drop strobe next cycle; rsp_valid=1, rsp_err=0 next cycle; go IDLE.
REQ-025 BUS, waitrequest=0, read: drop strobe next cycle; go RDATA.
REQ-026 RDATA: register readdata into rsp_rdata; rsp_valid=1, rsp_err=0 next cycle; go IDLE.
REQ-027 BUS, waitrequest=1: counter increments; if counter reaches TIMEOUT, drop strobe next cycle, rsp_valid=1, rsp_err=1, rsp_rdata unchanged, go IDLE.
REQ-028 Latency without wait states: write 2 cycles, read 3 cycles, counted from the accept edge to rsp_valid.
REQ-029 rsp_valid SHALL be high for exactly one cycle per accepted request; a new request may be accepted in the same cycle rsp_valid=1.
REQ-030 Inputs req_* SHALL be ignored outside IDLE; changes to them mid-access do not affect bus outputs.
REQ-031 Timeout counter width SHALL hold TIMEOUT without wrap; counter saturates, never wraps.
REQ-032 Strobes deasserted in IDLE and RDATA; address, writedata, byteenable don't-care when strobes low.

Reset
REQ-033 reset_n=0 at a rising edge SHALL force state IDLE, counter 0, read=write=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, address=0, writedata=0, byteenable=0.
REQ-034 Reset mid-access SHALL abandon the access with no rsp_valid; strobes low from the following cycle.

Verification
REQ-035 Read 0xBFC00000, waitrequest=0, readdata=0x3C081234 -> read high 1 cycle, rsp_valid in cycle 3, rsp_rdata=0x3C081234, rsp_err=0.
REQ-036 Write 0x00001000, wdata=0xDEADBEEF, be=4'b0011, waitrequest high 3 cycles -> write held 4 cycles with address/data/be stable, rsp_valid 1 cycle after release.
REQ-037 Read 0x00000002 -> no strobe, next cycle rsp_valid=1, rsp_err=1.
REQ-038 TIMEOUT=4, waitrequest stuck high -> strobe drops after 4 wait cycles, rsp_valid=1, rsp_err=1, req_ready=1 next.
REQ-039 reset_n=0 during BUS with waitrequest=1 -> strobes low next cycle, no rsp_valid, then back-to-back read and write complete normally.

Source files
------------

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - single-outstanding CPU request to memory-bus master with wait-state timeout
//
// Turns one CPU request at a time into a memory-bus read or write. Misaligned
// addresses are refused with an error. Writes with no byte lanes enabled complete
// with no bus access. A transfer stalled by waitrequest for TIMEOUT cycles is abandoned
// with an error.
//
// Ports
//   clk, reset_n      : system clock; synchronous active-low reset
//   req_valid         : CPU request strobe, taken only while req_ready=1
//   req_write         : 1 = write, 0 = read
//   req_addr          : word-aligned byte address
//   req_wdata         : write data
//   req_byteenable    : active byte lanes
//   req_ready         : block is idle and accepts a request this cycle
//   rsp_valid         : one-cycle completion pulse
//   rsp_err           : error flag for the completion (misaligned or timeout)
//   rsp_rdata         : read data for the completion
//   address           : bus address
//   read, write       : bus strobes
//   writedata         : bus write data
//   byteenable        : bus byte enables
//   waitrequest       : responder stall
//   readdata          : responder data, valid the cycle after a completed read

module mem_bus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byteenable,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);
  localparam logic [CW-1:0] TIMEOUT_M1  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_is_write;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;
  logic [CW-1:0]   r_wait_cnt;
  logic            r_rsp_valid;
  logic            r_rsp_err;
  logic [31:0]     r_rsp_rdata;
  logic            w_misaligned;
  logic            w_null_write;
  logic            w_timeout_hit;

  assign w_misaligned  = (req_addr[1:0] != 2'b00);
  assign w_null_write  = req_write && (req_byteenable == 4'b0000);
  // This wait cycle is the TIMEOUT-th consecutive one: the counter already holds TIMEOUT-1.
  assign w_timeout_hit = (r_wait_cnt >= TIMEOUT_M1);

  assign address    = r_addr;
  assign writedata  = r_wdata;
  assign byteenable = r_be;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_err    = r_rsp_err;
  assign rsp_rdata  = r_rsp_rdata;

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    read         = 1'b0;
    write        = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !w_misaligned && !w_null_write) begin
          w_state_next = BUS;
        end
      end
      BUS: begin
        read  = !r_is_write;
        write = r_is_write;
        if (!waitrequest) begin
          w_state_next = r_is_write ? IDLE : RDATA;
        end else if (w_timeout_hit) begin
          w_state_next = IDLE;
        end
      end
      RDATA: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_is_write  <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_be        <= 4'h0;
      r_wait_cnt  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_state     <= w_state_next;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (w_misaligned) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else if (w_null_write) begin
              r_rsp_valid <= 1'b1;
            end else begin
              r_is_write <= req_write;
              r_addr     <= req_addr;
              r_wdata    <= req_wdata;
              r_be       <= req_byteenable;
              r_wait_cnt <= '0;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            if (r_is_write) begin
              r_rsp_valid <= 1'b1;
            end
          end else if (w_timeout_hit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
          end else if (r_wait_cnt != TIMEOUT_CNT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        RDATA: begin
          r_rsp_rdata <= readdata;
          r_rsp_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - table-driven bench with response scoreboard for mem_bus_master
module tb_mem_bus_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_byteenable;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  mem_bus_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_byteenable(req_byteenable), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          nwait;
    logic [31:0] rdata;
    logic        exp_err;
    logic        exp_bus;
  } vec_t;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t        sb[$];
  vec_t        vecs[11];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [31:0] model_rdata = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_latency_cycle", cyc, e.due);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          chk("rsp_rdata", rsp_rdata, e.rdata);
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("rsp_missing_by_cycle", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  task automatic clear_req();
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_byteenable = 4'h0;
  endtask

  task automatic garble_req();
    req_valid = 1'b1; req_write = $urandom_range(0, 1);
    req_addr = $urandom; req_wdata = $urandom; req_byteenable = 4'($urandom);
  endtask

  task automatic strobes_idle(input string tag, input logic exp_ready);
    chk({tag, "_read_low"}, {31'b0, read}, 32'd0);
    chk({tag, "_write_low"}, {31'b0, write}, 32'd0);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, {31'b0, exp_ready});
  endtask

  // Drives one request; call with the DUT idle and away from the rising edge.
  task automatic run_vec(input vec_t v, input int idx);
    int   acc;
    int   n;
    rsp_t e;
    string tag;
    tag = $sformatf("v%0d", idx);
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr;
    req_wdata = v.wdata; req_byteenable = v.be; waitrequest = 1'b0;
    chk({tag, "_ready_at_req"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    n = v.exp_err ? TO : v.nwait + 1;
    e.err = v.exp_err;
    if (!v.exp_bus) begin
      e.due = acc;
    end else begin
      e.due = acc + n + ((!v.write && !v.exp_err) ? 1 : 0);
    end
    if (v.exp_bus && !v.write && !v.exp_err) model_rdata = v.rdata;
    e.rdata = model_rdata;
    sb.push_back(e);
    if (v.exp_bus) begin
      for (int c = 0; c < n; c++) begin
        garble_req();
        waitrequest = (c < v.nwait);
        readdata = $urandom;
        @(negedge clk);
        chk({tag, "_read_strobe"}, {31'b0, read}, {31'b0, !v.write});
        chk({tag, "_write_strobe"}, {31'b0, write}, {31'b0, v.write});
        chk({tag, "_address"}, address, v.addr);
        chk({tag, "_byteenable"}, {28'b0, byteenable}, {28'b0, v.be});
        if (v.write) chk({tag, "_writedata"}, writedata, v.wdata);
        chk({tag, "_busy_ready"}, {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
      end
      if (!v.write && !v.exp_err) begin
        garble_req();
        waitrequest = 1'b0;
        readdata = v.rdata;
        @(negedge clk);
        strobes_idle({tag, "_rdata"}, 1'b0);
        @(posedge clk); #1;
        readdata = $urandom;
      end
    end
    clear_req();
    waitrequest = 1'b0;
    @(negedge clk);
    strobes_idle({tag, "_rsp"}, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         wr    addr          wdata         be       nw  rdata         err   bus
    vecs[0]  = '{1'b0, 32'hBFC00000, 32'h0,        4'hF,    0, 32'h3C081234, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 32'h00001000, 32'hDEADBEEF, 4'b0011, 3, 32'h0,        1'b0, 1'b1};
    vecs[2]  = '{1'b0, 32'h00000002, 32'h0,        4'hF,    0, 32'h0,        1'b1, 1'b0};
    vecs[3]  = '{1'b1, 32'h00000003, 32'h11111111, 4'hF,    0, 32'h0,        1'b1, 1'b0};
    vecs[4]  = '{1'b1, 32'h00002000, 32'h22222222, 4'h0,    0, 32'h0,        1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'h00000004, 32'h0,        4'hF,    4, 32'h99999999, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 32'h00000008, 32'hCAFEF00D, 4'hF,    7, 32'h0,        1'b1, 1'b1};
    vecs[7]  = '{1'b0, 32'h00000010, 32'h0,        4'h5,    2, 32'h55AA33CC, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'hF,    1, 32'hA5A50F0F, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 32'hFFFFFFFC, 32'h12345678, 4'b1000, 0, 32'h0,        1'b0, 1'b1};
    vecs[10] = '{1'b0, 32'h00000020, 32'h0,        4'h0,    0, 32'h0BADCAFE, 1'b0, 1'b1};

    reset_n = 1'b0; clear_req(); waitrequest = 1'b0; readdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    strobes_idle("reset", 1'b1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_address", address, 32'h0);
    chk("reset_writedata", writedata, 32'h0);
    chk("reset_byteenable", {28'b0, byteenable}, 32'h0);
    mon_en = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset while stalled on the bus: the access vanishes without a response.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h00000040;
    req_wdata = 32'h0; req_byteenable = 4'hF; waitrequest = 1'b1;
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    chk("rst_mid_read_strobe", {31'b0, read}, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    strobes_idle("rst_mid", 1'b1);
    chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_mid_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mid_address", address, 32'h0);
    model_rdata = 32'h0;
    waitrequest = 1'b0;
    run_vec('{1'b0, 32'h00000100, 32'h0, 4'hF, 0, 32'h76543210, 1'b0, 1'b1}, 20);
    run_vec('{1'b1, 32'h00000104, 32'h0F1E2D3C, 4'b0110, 1, 32'h0, 1'b0, 1'b1}, 21);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
